// File: rtl/wb_scoreboard.sv
// Scoreboard for multi-cycle ops (divider, FPU): tracks in-flight destination registers
// and stalls decode on RAW/WAW hazards that MEM/WB forwarding cannot cover.
module wb_scoreboard #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned TAG_W     = $clog2(NUM_SLOTS),
    parameter int unsigned REG_W     = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    input  logic [REG_W-1:0] issue_rd_i,
    input  logic             issue_rd_fp_i,
    output logic             issue_ready_o,
    output logic [TAG_W-1:0] issue_tag_o,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic [REG_W-1:0] rs3_i,
    input  logic             rs1_fp_i,
    input  logic             rs2_fp_i,
    input  logic             rs3_fp_i,
    input  logic [2:0]       rs_used_i,
    input  logic             cmp_valid_i,
    input  logic [TAG_W-1:0] cmp_tag_i,
    output logic             stall_o,
    output logic [TAG_W:0]   inflight_cnt_o,
    output logic             err_o
);

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [NUM_SLOTS-1:0] fp_q, fp_d;
    logic [REG_W-1:0]     rd_q [NUM_SLOTS];
    logic [REG_W-1:0]     rd_d [NUM_SLOTS];
    logic [TAG_W:0]       cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 raw, waw, stall;
    logic                 ready, accept, cmp_ok;
    logic                 found;
    logic [TAG_W-1:0]     free_tag;

    // Integer x0 is hardwired to zero and never creates a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] addr, input logic addr_fp,
                                     input logic [REG_W-1:0] slot_rd, input logic slot_fp);
        return (addr_fp == slot_fp) && (addr == slot_rd) && !(!addr_fp && (addr == '0));
    endfunction

    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i]) begin
                raw = raw | (rs_used_i[0] && reg_hit(rs1_i, rs1_fp_i, rd_q[i], fp_q[i]))
                          | (rs_used_i[1] && reg_hit(rs2_i, rs2_fp_i, rd_q[i], fp_q[i]))
                          | (rs_used_i[2] && reg_hit(rs3_i, rs3_fp_i, rd_q[i], fp_q[i]));
                waw = waw | (issue_valid_i && reg_hit(issue_rd_i, issue_rd_fp_i,
                                                      rd_q[i], fp_q[i]));
            end
        end
    end

    always_comb begin
        free_tag = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!valid_q[i] && !found) begin
                free_tag = TAG_W'(i);
                found    = 1'b1;
            end
        end
    end

    assign stall  = raw | waw;
    assign ready  = ~&valid_q;
    assign accept = issue_valid_i & ready & ~stall & ~flush_i;
    assign cmp_ok = cmp_valid_i & valid_q[cmp_tag_i];

    // Completion clears on pre-edge state, so a slot freed this cycle is not reused until next.
    always_comb begin
        valid_d = valid_q;
        fp_d    = fp_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (flush_i) begin
            valid_d = '0;
            cnt_d   = '0;
        end else begin
            if (cmp_valid_i) begin
                if (cmp_ok) begin
                    valid_d[cmp_tag_i] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (accept) begin
                valid_d[free_tag] = 1'b1;
                rd_d[free_tag]    = issue_rd_i;
                fp_d[free_tag]    = issue_rd_fp_i;
            end
            if (accept && !cmp_ok) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!accept && cmp_ok) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            fp_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            fp_q    <= fp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign issue_ready_o  = ready;
    assign issue_tag_o    = free_tag;
    assign stall_o        = stall;
    assign inflight_cnt_o = cnt_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized traffic
// checked against a slot-list reference model.
module tb_wb_scoreboard;

    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       iv = 1'b0;
    logic [4:0] ird = '0;
    logic       ifp = 1'b0;
    logic       issue_ready;
    logic [1:0] issue_tag;
    logic [4:0] rs1 = '0, rs2 = '0, rs3 = '0;
    logic       fp1 = 1'b0, fp2 = 1'b0, fp3 = 1'b0;
    logic [2:0] used = '0;
    logic       cv = 1'b0;
    logic [1:0] ctag = '0;
    logic       stall;
    logic [2:0] cnt;
    logic       err;

    int total = 0;
    int bad = 0;

    // Reference model: a list of in-flight entries indexed by tag.
    bit         m_valid [NS];
    logic [4:0] m_rd    [NS];
    bit         m_fp    [NS];
    bit         m_err;

    wb_scoreboard #(.NUM_SLOTS(4), .TAG_W(2), .REG_W(5)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .issue_valid_i  (iv),
        .issue_rd_i     (ird),
        .issue_rd_fp_i  (ifp),
        .issue_ready_o  (issue_ready),
        .issue_tag_o    (issue_tag),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .rs3_i          (rs3),
        .rs1_fp_i       (fp1),
        .rs2_fp_i       (fp2),
        .rs3_fp_i       (fp3),
        .rs_used_i      (used),
        .cmp_valid_i    (cv),
        .cmp_tag_i      (ctag),
        .stall_o        (stall),
        .inflight_cnt_o (cnt),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit m_hit(logic [4:0] a, bit f);
        if (!f && a == 5'd0) return 1'b0;
        for (int i = 0; i < NS; i++)
            if (m_valid[i] && m_rd[i] == a && m_fp[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return (used[0] && m_hit(rs1, fp1)) || (used[1] && m_hit(rs2, fp2)) ||
               (used[2] && m_hit(rs3, fp3)) || (iv && m_hit(ird, ifp));
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NS; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_tag();
        for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 1'b0;
            m_rd[i]    = '0;
            m_fp[i]    = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // One clock: model decides from pre-edge state and current inputs, then updates.
    task automatic tick();
        bit acc;
        int t;
        acc = iv && (m_cnt() < NS) && !m_stall() && !flush;
        t = m_tag();
        @(posedge clk);
        if (flush) begin
            for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        end else begin
            if (cv) begin
                if (m_valid[ctag]) m_valid[ctag] = 1'b0;
                else m_err = 1'b1;
            end
            if (acc) begin
                m_valid[t] = 1'b1;
                m_rd[t]    = ird;
                m_fp[t]    = ifp;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0; iv = 1'b0; ird = '0; ifp = 1'b0; cv = 1'b0; ctag = '0;
        rs1 = '0; rs2 = '0; rs3 = '0; fp1 = 1'b0; fp2 = 1'b0; fp3 = 1'b0; used = '0;
    endtask

    task automatic issue(logic [4:0] rd, logic fp);
        iv = 1'b1; ird = rd; ifp = fp;
        tick();
        iv = 1'b0;
    endtask

    task automatic complete(logic [1:0] tag);
        cv = 1'b1; ctag = tag;
        tick();
        cv = 1'b0;
    endtask

    task automatic test_reset();
        used = 3'b111; rs1 = 5'd5; rs2 = 5'd6; iv = 1'b1; ird = 5'd5;
        #1;
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", issue_ready); end
        total++; if (issue_tag !== 2'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", issue_tag); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_empty got=%0b want=0", stall); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
        clear_inputs();
    endtask

    task automatic test_basic();
        iv = 1'b1; ird = 5'd5; ifp = 1'b0;
        #1;
        total++; if (issue_tag !== 2'd0) begin bad++; $display("FAIL basic_tag got=%0d want=0", issue_tag); end
        tick();
        iv = 1'b0;
        total++; if (cnt !== 3'd1) begin bad++; $display("FAIL basic_cnt1 got=%0d want=1", cnt); end
        rs1 = 5'd5; used = 3'b001;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL basic_raw got=%0b want=1", stall); end
        cv = 1'b1; ctag = 2'd0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL basic_raw_during_cmp got=%0b want=1", stall); end
        tick();
        cv = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL basic_raw_after_cmp got=%0b want=0", stall); end
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL basic_cnt0 got=%0d want=0", cnt); end
        clear_inputs();
    endtask

    task automatic test_file_and_x0();
        issue(5'd3, 1'b0);
        rs2 = 5'd3; fp2 = 1'b1; used = 3'b010;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL file_mismatch got=%0b want=0", stall); end
        iv = 1'b1; ird = 5'd0; ifp = 1'b0;
        #1;
        total++; if (issue_tag !== 2'd1) begin bad++; $display("FAIL x0_tag got=%0d want=1", issue_tag); end
        tick();
        total++; if (cnt !== 3'd2) begin bad++; $display("FAIL x0_accept_cnt got=%0d want=2", cnt); end
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_waw got=%0b want=0", stall); end
        iv = 1'b0; rs1 = 5'd0; fp1 = 1'b0; used = 3'b001;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_raw got=%0b want=0", stall); end
        clear_inputs();
        complete(2'd0);
        complete(2'd1);
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL x0_drain got=%0d want=0", cnt); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1; ird = 5'(i + 1); ifp = 1'b0;
            #1;
            total++; if (issue_tag !== 2'(i)) begin bad++; $display("FAIL full_tag%0d got=%0d want=%0d", i, issue_tag, i); end
            tick();
        end
        iv = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", issue_ready); end
        issue(5'd9, 1'b0);
        total++; if (cnt !== 3'd4) begin bad++; $display("FAIL full_refuse got=%0d want=4", cnt); end
        iv = 1'b1; ird = 5'd9; cv = 1'b1; ctag = 2'd2;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_same_cycle_ready got=%0b want=0", issue_ready); end
        tick();
        iv = 1'b0; cv = 1'b0;
        #1;
        total++; if (cnt !== 3'd3) begin bad++; $display("FAIL full_after_cmp_cnt got=%0d want=3", cnt); end
        total++; if (issue_tag !== 2'd2) begin bad++; $display("FAIL full_freed_tag got=%0d want=2", issue_tag); end
        complete(2'd0);
        complete(2'd1);
        complete(2'd3);
        clear_inputs();
    endtask

    task automatic test_waw();
        issue(5'd7, 1'b1);
        iv = 1'b1; ird = 5'd7; ifp = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%0b want=1", stall); end
        tick();
        total++; if (cnt !== 3'd1) begin bad++; $display("FAIL waw_cnt got=%0d want=1", cnt); end
        ifp = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_file_mismatch got=%0b want=0", stall); end
        iv = 1'b0;
        complete(2'd0);
        clear_inputs();
    endtask

    task automatic test_flush();
        issue(5'd10, 1'b0);
        issue(5'd11, 1'b0);
        issue(5'd12, 1'b0);
        flush = 1'b1; iv = 1'b1; ird = 5'd13; cv = 1'b1; ctag = 2'd1;
        tick();
        clear_inputs();
        #1;
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL flush_cnt got=%0d want=0", cnt); end
        total++; if (issue_tag !== 2'd0 || issue_ready !== 1'b1) begin bad++; $display("FAIL flush_free got tag=%0d rdy=%0b want tag=0 rdy=1", issue_tag, issue_ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL flush_err got=%0b want=0", err); end
        complete(2'd1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL stale_cmp_err got=%0b want=1", err); end
        tick();
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b want=1", err); end
    endtask

    task automatic test_async_reset();
        issue(5'd20, 1'b0);
        issue(5'd21, 1'b0);
        issue(5'd22, 1'b0);
        rs1 = 5'd20; used = 3'b001;
        #1;
        total++; if (cnt !== 3'd3 || stall !== 1'b1) begin bad++; $display("FAIL pre_reset got cnt=%0d stall=%0b want cnt=3 stall=1", cnt, stall); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL async_cnt got=%0d want=0", cnt); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL async_stall got=%0b want=0", stall); end
        total++; if (issue_ready !== 1'b1 || issue_tag !== 2'd0) begin bad++; $display("FAIL async_issue got rdy=%0b tag=%0d want rdy=1 tag=0", issue_ready, issue_tag); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL async_err got=%0b want=0", err); end
        m_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        int start;
        for (int n = 0; n < 500; n++) begin
            flush = ($urandom_range(0, 99) < 3);
            iv    = 1'($urandom_range(0, 1));
            ird   = 5'($urandom_range(0, 7));
            ifp   = 1'($urandom_range(0, 1));
            rs1   = 5'($urandom_range(0, 7));
            rs2   = 5'($urandom_range(0, 7));
            rs3   = 5'($urandom_range(0, 7));
            fp1   = 1'($urandom_range(0, 1));
            fp2   = 1'($urandom_range(0, 1));
            fp3   = 1'($urandom_range(0, 1));
            used  = 3'($urandom_range(0, 7));
            cv    = ($urandom_range(0, 99) < 35);
            ctag  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) != 0) begin
                start = $urandom_range(0, 3);
                for (int k = 0; k < NS; k++)
                    if (m_valid[(start + k) % NS]) ctag = 2'((start + k) % NS);
            end
            #1;
            total++; if (stall !== m_stall()) begin bad++; $display("FAIL rnd_stall n=%0d got=%0b want=%0b", n, stall, m_stall()); end
            total++; if (issue_ready !== (m_cnt() < NS)) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b want=%0b", n, issue_ready, m_cnt() < NS); end
            total++; if (issue_tag !== 2'(m_tag())) begin bad++; $display("FAIL rnd_tag n=%0d got=%0d want=%0d", n, issue_tag, m_tag()); end
            total++; if (cnt !== 3'(m_cnt())) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, cnt, m_cnt()); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%0b want=%0b", n, err, m_err); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        m_reset();
        clear_inputs();
        #23;
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_file_and_x0();
        test_full();
        test_waw();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
